// File: rtl/fc1_sched.sv
// fc1_sched -- issue sequencer for the FC1 multiply-accumulate datapath.
//
// Walks species (s) x output neuron (j) x input element (i), innermost i.
// Each issued beat reads one input sample and one weight. One cycle later
// the accumulator strobes follow, and two cycles later the finished neuron
// is written to the output RAM.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset, aborts any pass in flight
//   start      begin a full layer pass (only honoured while idle)
//   stall      freeze issue; beats already issued keep moving
//   w_en       data RAM / weight ROM read enable
//   data_addr  s*IN_NUM + i of the issued beat
//   w_addr     j*IN_NUM + i of the issued beat
//   bias_en    bias read enable, on the issue of i==0
//   bias_addr  j of the issued beat
//   acc_clr    first MAC beat of a neuron (load instead of add)
//   acc_en     MAC beat valid
//   acc_last   final MAC beat of a neuron
//   out_we     output RAM write enable
//   out_addr   s*OUT_NUM + j of the neuron being written (held between writes)
//   busy       pass in progress
//   done       one-cycle pulse after the final output write
module fc1_sched #(
    parameter int SPECIES = 42,
    parameter int IN_NUM  = 480,
    parameter int OUT_NUM = 64,
    parameter int DA_W    = 15,
    parameter int WA_W    = 15,
    parameter int OA_W    = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    output logic            w_en,
    output logic [DA_W-1:0] data_addr,
    output logic [WA_W-1:0] w_addr,
    output logic            bias_en,
    output logic [5:0]      bias_addr,
    output logic            acc_clr,
    output logic            acc_en,
    output logic            acc_last,
    output logic            out_we,
    output logic [OA_W-1:0] out_addr,
    output logic            busy,
    output logic            done
);

    localparam int IW = $clog2(IN_NUM + 1);
    localparam int JW = $clog2(OUT_NUM + 1);
    localparam int SW = $clog2(SPECIES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    state_t          state_d;
    logic [IW-1:0]   i_cnt;
    logic [JW-1:0]   j_cnt;
    logic [SW-1:0]   s_cnt;
    logic [DA_W-1:0] d_base;
    logic [DA_W-1:0] d_ptr;
    logic [WA_W-1:0] w_ptr;
    logic [OA_W-1:0] o_ptr;
    logic            drain_cnt;
    logic            issue;
    logic            i_last;
    logic            j_last;
    logic            s_last;
    logic            iss_last;
    logic [OA_W-1:0] iss_oaddr;
    logic [OA_W-1:0] last_oaddr;

    assign i_last = (i_cnt == IW'(IN_NUM - 1));
    assign j_last = (j_cnt == JW'(OUT_NUM - 1));
    assign s_last = (s_cnt == SW'(SPECIES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic. A beat issues on every unstalled RUN cycle; the beat
    // with all three counters at their last value moves us into DRAIN.
    always_comb begin
        state_d = state;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!stall) begin
                    issue = 1'b1;
                    if (i_last && j_last && s_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Two DRAIN cycles let the last beat reach the output write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_cnt <= 1'b0;
        end else begin
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // Loop counters and address pointers. Products are never formed: the
    // data pointer restarts from the per-species base on each new neuron,
    // the weight pointer just counts through all neurons of one species,
    // and the output index counts finished neurons. Everything wraps to 0
    // after the final beat so the next pass starts clean.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_cnt  <= '0;
            j_cnt  <= '0;
            s_cnt  <= '0;
            d_base <= '0;
            d_ptr  <= '0;
            w_ptr  <= '0;
            o_ptr  <= '0;
        end else if (issue) begin
            if (!i_last) begin
                i_cnt <= i_cnt + 1'b1;
                d_ptr <= d_ptr + 1'b1;
                w_ptr <= w_ptr + 1'b1;
            end else begin
                i_cnt <= '0;
                if (!j_last) begin
                    j_cnt <= j_cnt + 1'b1;
                    w_ptr <= w_ptr + 1'b1;
                    d_ptr <= d_base;
                    o_ptr <= o_ptr + 1'b1;
                end else begin
                    j_cnt <= '0;
                    w_ptr <= '0;
                    if (!s_last) begin
                        s_cnt  <= s_cnt + 1'b1;
                        d_base <= d_base + DA_W'(IN_NUM);
                        d_ptr  <= d_base + DA_W'(IN_NUM);
                        o_ptr  <= o_ptr + 1'b1;
                    end else begin
                        s_cnt  <= '0;
                        d_base <= '0;
                        d_ptr  <= '0;
                        o_ptr  <= '0;
                    end
                end
            end
        end
    end

    // Registered outputs. The issue stage latches the addresses, the next
    // stage raises the accumulator strobes, and the stage after that writes
    // the neuron result. The neuron's output index travels alongside so a
    // write and the next neuron's clear can overlap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_en       <= 1'b0;
            data_addr  <= '0;
            w_addr     <= '0;
            bias_en    <= 1'b0;
            bias_addr  <= '0;
            acc_clr    <= 1'b0;
            acc_en     <= 1'b0;
            acc_last   <= 1'b0;
            out_we     <= 1'b0;
            out_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            iss_last   <= 1'b0;
            iss_oaddr  <= '0;
            last_oaddr <= '0;
        end else begin
            w_en    <= issue;
            bias_en <= issue && (i_cnt == '0);
            if (issue) begin
                data_addr <= d_ptr;
                w_addr    <= w_ptr;
                bias_addr <= 6'(j_cnt);
                iss_last  <= i_last;
                iss_oaddr <= o_ptr;
            end
            acc_en     <= w_en;
            acc_clr    <= bias_en;
            acc_last   <= w_en && iss_last;
            last_oaddr <= iss_oaddr;
            out_we     <= acc_last;
            if (acc_last) begin
                out_addr <= last_oaddr;
            end
            busy <= (state == RUN) || (state == DRAIN);
            done <= (state == DONE);
        end
    end

endmodule
